// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command-packet receive path and its downstream decoders.
`default_nettype none

package spi_pkg;

    localparam int SPI_PACKET_W = 24;
    localparam int SPI_CMD_W    = 8;
    localparam int SPI_DATA_W   = SPI_PACKET_W - SPI_CMD_W;

    typedef struct packed {
        logic [SPI_CMD_W-1:0]  cmd;
        logic [SPI_DATA_W-1:0] data;
    } spi_packet_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_rx_state_t;

    // Command codes understood by the waveform/sign generator.
    localparam logic [SPI_CMD_W-1:0] CMD_NOP      = 8'h00;
    localparam logic [SPI_CMD_W-1:0] CMD_SET_FREQ = 8'h01;
    localparam logic [SPI_CMD_W-1:0] CMD_SET_AMP  = 8'h02;
    localparam logic [SPI_CMD_W-1:0] CMD_SET_WAVE = 8'h03;

endpackage

`default_nettype wire

// File: rtl/spi_packet_rx_sync_edge.sv
// N-stage pin synchroniser with registered output and single-cycle rise/fall pulses.
`default_nettype none

module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~prev_q;
    assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_packet_rx.sv
// SPI slave front end: deserialises fixed-length command packets into the core clock
// domain and presents them over a valid/ready handshake.
`default_nettype none

module spi_packet_rx
    import spi_pkg::*;
#(
    parameter int PACKET_W    = SPI_PACKET_W,
    parameter int CMD_W       = SPI_CMD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   sck,
    input  logic                   sdi,
    output logic [CMD_W-1:0]       pkt_cmd,
    output logic [PACKET_W-CMD_W-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int DATA_W = PACKET_W - CMD_W;
    localparam int CNT_W  = $clog2(PACKET_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACKET_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PACKET_W + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic sdi_s, sdi_rise, sdi_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i (clk),   .rst_i (reset), .d_i (cs),
        .q_o   (cs_s),  .rise_o(cs_rise), .fall_o(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i (clk),   .rst_i (reset), .d_i (sck),
        .q_o   (sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk_i (clk),   .rst_i (reset), .d_i (sdi),
        .q_o   (sdi_s), .rise_o(sdi_rise), .fall_o(sdi_fall)
    );

    logic unused_edges;
    assign unused_edges = sck_s & sck_fall & sdi_rise & sdi_fall;

    spi_rx_state_t         state_q, state_d;
    logic [PACKET_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PACKET_W-1:0]   pkt_q, pkt_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  commit;
    logic                  count_ok;
    logic                  load;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A clock edge coinciding with the cs fall is not part of the frame.
                if (cs_fall) begin
                    state_d = COMMIT;
                end else if (sck_rise && cs_s) begin
                    shift_d = {shift_q[PACKET_W-2:0], sdi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
                if (cs_rise) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The holding register is free if empty or being drained in this very cycle.
    assign count_ok = (cnt_q == CNT_FULL);
    assign load     = commit && count_ok && (!valid_q || pkt_ready);

    always_comb begin
        pkt_d       = load ? shift_q : pkt_q;
        valid_d     = load | (valid_q & ~pkt_ready);
        overrun_d   = commit && count_ok && valid_q && !pkt_ready;
        frame_err_d = commit && !count_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            pkt_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            pkt_q       <= pkt_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pkt_cmd   = pkt_q[PACKET_W-1:DATA_W];
    assign pkt_data  = pkt_q[DATA_W-1:0];
    assign pkt_valid = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_packet_rx.sv
// Scoreboard bench for spi_packet_rx: expected packets queued at stimulus, checked on accept.
`default_nettype none

module tb_spi_packet_rx;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic [7:0]  pkt_cmd;
    logic [15:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic        frame_err;
    logic        overrun;

    spi_packet_rx dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sck       (sck),
        .sdi       (sdi),
        .pkt_cmd   (pkt_cmd),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    spi_packet_t sb_q[$];
    int acc_cnt = 0, err_cnt = 0, ovr_cnt = 0, vld_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: every accept pops the scoreboard; pulses are tallied for the tests.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) err_cnt++;
            if (overrun)   ovr_cnt++;
            if (pkt_valid) vld_cnt++;
            if (pkt_valid && pkt_ready) begin
                acc_cnt++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    spi_packet_t e;
                    e = sb_q.pop_front();
                    check("pkt_cmd", {24'd0, pkt_cmd}, {24'd0, e.cmd});
                    check("pkt_data", {16'd0, pkt_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = val[i];
            clks(2);
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
            clks(2);
        end
    endtask

    task automatic send_frame(input logic [31:0] val, input int n);
        cs = 1'b1;
        clks(4);
        send_bits(val, n);
        cs = 1'b0;
        clks(12);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, pkt_valid}, 32'd0);
        check({tag, "_cmd"},   {24'd0, pkt_cmd},   32'd0);
        check({tag, "_data"},  {16'd0, pkt_data},  32'd0);
        check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
        check({tag, "_ovr"},   {31'd0, overrun},   32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!pkt_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!pkt_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int a0, e0, o0, v0, k;

        check_reset_outputs("rst");
        clks(3);
        reset = 1'b0;
        clks(4);

        // 1: single frame, consumer always ready
        pkt_ready = 1'b1;
        a0 = acc_cnt; e0 = err_cnt; o0 = ovr_cnt;
        sb_q.push_back(24'h0114ff);
        send_frame(32'h0114ff, 24);
        check("t1_accepts", acc_cnt - a0, 32'd1);
        check("t1_ferr",    err_cnt - e0, 32'd0);
        check("t1_ovr",     ovr_cnt - o0, 32'd0);

        // 2: packet held while consumer stalls, then accepted
        pkt_ready = 1'b0;
        sb_q.push_back(24'hA55A3C);
        send_frame(32'hA55A3C, 24);
        wait_valid("t2");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold_valid", {31'd0, pkt_valid}, 32'd1);
            check("t2_hold_pkt", {8'd0, pkt_cmd, pkt_data}, 32'hA55A3C);
        end
        @(posedge clk); #1;
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        @(negedge clk);
        check("t2_valid_drop", {31'd0, pkt_valid}, 32'd0);

        // 3: second frame while full -> overrun, first packet retained
        a0 = acc_cnt; e0 = err_cnt; o0 = ovr_cnt;
        sb_q.push_back(24'h0114ff);
        send_frame(32'h0114ff, 24);
        send_frame(32'h020001, 24);
        @(negedge clk);
        check("t3_ovr",   ovr_cnt - o0, 32'd1);
        check("t3_ferr",  err_cnt - e0, 32'd0);
        check("t3_valid", {31'd0, pkt_valid}, 32'd1);
        check("t3_pkt",   {8'd0, pkt_cmd, pkt_data}, 32'h0114ff);
        pkt_ready = 1'b1;
        clks(3);
        pkt_ready = 1'b0;
        check("t3_accepts", acc_cnt - a0, 32'd1);

        // 4: short and long frames
        e0 = err_cnt; v0 = vld_cnt; o0 = ovr_cnt;
        send_frame(32'h0114ff, 23);
        send_frame(32'h1234567, 25);
        check("t4_ferr",  err_cnt - e0, 32'd2);
        check("t4_valid", vld_cnt - v0, 32'd0);
        check("t4_ovr",   ovr_cnt - o0, 32'd0);

        // 5: drain in the exact COMMIT cycle of the next frame -> no bubble
        sb_q.push_back(24'h0114ff);
        send_frame(32'h0114ff, 24);
        wait_valid("t5a");
        sb_q.push_back(24'h030102);
        cs = 1'b1;
        clks(4);
        send_bits(32'h030102, 24);
        cs = 1'b0;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (dut.state_q != COMMIT && k < 20);
        check("t5_commit_seen", {31'd0, dut.state_q == COMMIT}, 32'd1);
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_bubble", {31'd0, pkt_valid}, 32'd1);
        end
        check("t5_pkt", {8'd0, pkt_cmd, pkt_data}, 32'h030102);
        clks(1);
        pkt_ready = 1'b1;
        clks(3);
        pkt_ready = 1'b0;

        // 6: reset in mid-frame with cs held high
        a0 = acc_cnt; e0 = err_cnt;
        cs = 1'b1;
        clks(4);
        send_bits(32'h0114ff >> 12, 12);
        reset = 1'b1;
        check_reset_outputs("t6_rst");
        clks(3);
        reset = 1'b0;
        clks(6);
        send_bits(32'h0114ff, 12);
        cs = 1'b0;
        clks(12);
        check("t6_ferr",    err_cnt - e0, 32'd1);
        check("t6_accepts", acc_cnt - a0, 32'd0);
        pkt_ready = 1'b1;
        sb_q.push_back(24'h02abcd);
        send_frame(32'h02abcd, 24);
        check("t6_clean_accepts", acc_cnt - a0, 32'd1);
        check("t6_clean_ferr",    err_cnt - e0, 32'd1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
